// File: rtl/cfo_comp.sv
// cfo_comp: carrier-frequency-offset compensation stage.
// Latches a per-sample phase step on short-preamble detect, runs a
// wrapping phase accumulator and sends each sample with its phase to a
// shared rotator, forwarding the rotated results in request order.
// Ports:
//   clock, reset             : clock, async active-high reset
//   enable, clear            : global hold, end-of-packet pulse
//   sample_in(_strobe)       : I [31:16] / Q [15:0] input samples
//   short_preamble_detected  : detect pulse, phase_offset valid with it
//   rot_i/rot_q/rot_phase    : rotator request, strobed by rot_in_stb
//   rot_out(_stb)            : rotator result
//   sample_out(_strobe)      : corrected sample stream
//   locked, overflow         : in TRACK, sticky outstanding error
module cfo_comp #(
  parameter int PI              = 1608,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] sample_in,
  input  logic        sample_in_strobe,
  input  logic        short_preamble_detected,
  input  logic [31:0] phase_offset,
  output logic [15:0] rot_i,
  output logic [15:0] rot_q,
  output logic [31:0] rot_phase,
  output logic        rot_in_stb,
  input  logic [31:0] rot_out,
  input  logic        rot_out_stb,
  output logic [31:0] sample_out,
  output logic        sample_out_strobe,
  output logic        locked,
  output logic        overflow
);

  localparam int PW = $clog2(MAX_OUTSTANDING + 2);
  localparam logic [PW-1:0] PMAX = PW'(MAX_OUTSTANDING + 1);

  localparam logic signed [31:0] LIM    = 32'(PI - 1);
  localparam logic signed [32:0] PI33   = 33'(PI);
  localparam logic signed [32:0] NPI33  = -33'(PI);
  localparam logic signed [32:0] TPI33  = 33'(2 * PI);

  typedef enum logic {
    S_IDLE,
    S_TRACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [31:0] r_acc;
  logic signed [31:0] r_inc;
  logic [PW-1:0]      r_pend;

  logic signed [31:0] w_off;
  logic signed [31:0] w_clamp;
  logic signed [32:0] w_sum;
  logic signed [31:0] w_wrap;
  logic               w_in;
  logic               w_up;
  logic               w_dn;
  logic               w_det;
  logic               w_clr;

  assign w_in  = enable & sample_in_strobe;
  assign w_up  = w_in;
  assign w_dn  = enable & rot_out_stb;
  assign w_clr = enable & clear;
  // clear beats a same-cycle detection
  assign w_det = enable & short_preamble_detected & ~clear;

  assign w_off = $signed(phase_offset);

  always_comb begin
    w_clamp = w_off;
    if (w_off > LIM) begin
      w_clamp = LIM;
    end else if (w_off < -LIM) begin
      w_clamp = -LIM;
    end
  end

  // sum taken one bit wider so acc + inc cannot overflow before wrapping
  assign w_sum = {r_acc[31], r_acc} + {r_inc[31], r_inc};

  always_comb begin
    w_wrap = 32'(w_sum);
    if (w_sum >= PI33) begin
      w_wrap = 32'(w_sum - TPI33);
    end else if (w_sum < NPI33) begin
      w_wrap = 32'(w_sum + TPI33);
    end
  end

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_det) w_next = S_TRACK;
      S_TRACK: if (w_clr) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state outputs
  always_comb begin
    locked = 1'b0;
    if (r_state == S_TRACK) begin
      locked = 1'b1;
    end
  end

  // phase step and accumulator
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_inc <= '0;
    end else if (enable) begin
      if (r_state == S_IDLE) begin
        if (w_det) begin
          r_inc <= w_clamp;
          r_acc <= '0;
        end
      end else begin
        if (clear) begin
          r_acc <= '0;
          r_inc <= '0;
        end else if (sample_in_strobe) begin
          r_acc <= w_wrap;
        end
      end
    end
  end

  // rotator request; IDLE sends phase 0 so latency is state-independent
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rot_i      <= '0;
      rot_q      <= '0;
      rot_phase  <= '0;
      rot_in_stb <= 1'b0;
    end else begin
      rot_in_stb <= w_in;
      if (w_in) begin
        rot_i     <= sample_in[31:16];
        rot_q     <= sample_in[15:0];
        rot_phase <= (r_state == S_TRACK) ? r_acc : '0;
      end
    end
  end

  // result forwarding
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_out        <= '0;
      sample_out_strobe <= 1'b0;
    end else begin
      sample_out_strobe <= w_dn;
      if (w_dn) begin
        sample_out <= rot_out;
      end
    end
  end

  // outstanding requests, counted when the request is issued
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend   <= '0;
      overflow <= 1'b0;
    end else begin
      unique case ({w_up, w_dn})
        2'b10: begin
          if (r_pend == PMAX) begin
            overflow <= 1'b1;
          end else begin
            r_pend <= r_pend + 1'b1;
            if (r_pend + 1'b1 == PMAX) begin
              overflow <= 1'b1;
            end
          end
        end
        2'b01: begin
          if (r_pend == '0) begin
            overflow <= 1'b1;
          end else begin
            r_pend <= r_pend - 1'b1;
          end
        end
        default: r_pend <= r_pend;
      endcase
    end
  end

endmodule

// File: tb/tb_cfo_comp.sv
// tb_cfo_comp: directed bench for cfo_comp with a 3-cycle
// in-order rotator model that swaps I and Q.
module tb_cfo_comp;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [31:0] sample_in;
  logic        sample_in_strobe;
  logic        short_preamble_detected;
  logic [31:0] phase_offset;
  logic [15:0] rot_i;
  logic [15:0] rot_q;
  logic [31:0] rot_phase;
  logic        rot_in_stb;
  logic [31:0] rot_out;
  logic        rot_out_stb;
  logic [31:0] sample_out;
  logic        sample_out_strobe;
  logic        locked;
  logic        overflow;

  int n_tests;
  int n_fail;

  logic        model_en;
  logic        spur;
  logic [31:0] spur_data;
  logic        m_p1, m_p2, m_stb;
  logic [31:0] m_d1, m_d2, m_d3;

  cfo_comp dut (
    .clock                  (clock),
    .reset                  (reset),
    .enable                 (enable),
    .clear                  (clear),
    .sample_in              (sample_in),
    .sample_in_strobe       (sample_in_strobe),
    .short_preamble_detected(short_preamble_detected),
    .phase_offset           (phase_offset),
    .rot_i                  (rot_i),
    .rot_q                  (rot_q),
    .rot_phase              (rot_phase),
    .rot_in_stb             (rot_in_stb),
    .rot_out                (rot_out),
    .rot_out_stb            (rot_out_stb),
    .sample_out             (sample_out),
    .sample_out_strobe      (sample_out_strobe),
    .locked                 (locked),
    .overflow               (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    m_p1  <= rot_in_stb & model_en;
    m_p2  <= m_p1;
    m_stb <= m_p2;
    m_d1  <= {rot_q, rot_i};
    m_d2  <= m_d1;
    m_d3  <= m_d2;
  end

  assign rot_out_stb = m_stb | spur;
  assign rot_out     = spur ? spur_data : m_d3;

  typedef struct {
    logic [31:0] off;
    int          exp [5];
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (%h) expected %0d (%h)", nm,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic send(input logic [31:0] s);
    sample_in        = s;
    sample_in_strobe = 1'b1;
    tick();
  endtask

  task automatic idle_in();
    sample_in_strobe        = 1'b0;
    short_preamble_detected = 1'b0;
    clear                   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int wrapm(input int x);
    if (x >= 1608) return x - 3216;
    if (x < -1608) return x + 3216;
    return x;
  endfunction

  initial begin
    int lat;
    int macc;
    int oor;
    n_tests   = 0;
    n_fail    = 0;
    enable    = 1'b1;
    clear     = 1'b0;
    sample_in = '0;
    sample_in_strobe        = 1'b0;
    short_preamble_detected = 1'b0;
    phase_offset = '0;
    model_en  = 1'b1;
    spur      = 1'b0;
    spur_data = '0;

    tbl[0].off = 32'd100;
    tbl[0].exp = '{0, 100, 200, 300, 400};
    tbl[1].off = 32'd1000;
    tbl[1].exp = '{0, 1000, -1216, -216, 784};
    tbl[2].off = -32'sd1000;
    tbl[2].exp = '{0, -1000, 1216, 216, -784};
    tbl[3].off = 32'd5000;
    tbl[3].exp = '{0, 1607, -2, 1605, -4};
    tbl[4].off = -32'sd5000;
    tbl[4].exp = '{0, -1607, 2, -1605, 4};

    reset = 1'b1;
    tick();
    chk("rst_rot_in_stb", 32'(rot_in_stb), 0);
    chk("rst_rot_phase", rot_phase, 0);
    chk("rst_rot_iq", {rot_i, rot_q}, 0);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_out_strobe", 32'(sample_out_strobe), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_overflow", 32'(overflow), 0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      send({16'(i + 1), 16'(16'h0100 + i)});
      chk("idle_rot_in_stb", 32'(rot_in_stb), 1);
      chk("idle_rot_phase", rot_phase, 0);
      chk("idle_rot_iq", {rot_i, rot_q},
          {16'(i + 1), 16'(16'h0100 + i)});
    end
    idle_in();
    tick();
    chk("idle_stb_drop", 32'(rot_in_stb), 0);
    chk("idle_locked", 32'(locked), 0);
    repeat (6) tick();

    send(32'hAAAA_5555);
    idle_in();
    lat = 1;
    while (!sample_out_strobe && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 5);
    chk("latency_data", sample_out, 32'h5555_AAAA);
    tick();

    for (int r = 0; r < 5; r++) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      phase_offset = tbl[r].off;
      short_preamble_detected = 1'b1;
      tick();
      short_preamble_detected = 1'b0;
      chk("tbl_locked", 32'(locked), 1);
      for (int j = 0; j < 5; j++) begin
        send(32'(r * 16 + j));
        chk($sformatf("tbl%0d_phase%0d", r, j), rot_phase,
            32'(tbl[r].exp[j]));
      end
      idle_in();
    end

    clear = 1'b1;
    tick();
    clear = 1'b0;
    phase_offset = 32'd5000;
    short_preamble_detected = 1'b1;
    tick();
    short_preamble_detected = 1'b0;
    macc = 0;
    oor  = 0;
    for (int k = 0; k < 1000; k++) begin
      send(32'(k));
      chk("long_phase", rot_phase, 32'(macc));
      if ($signed(rot_phase) < -1608 || $signed(rot_phase) > 1607)
        oor++;
      macc = wrapm(macc + 1607);
    end
    idle_in();
    chk("long_range", 32'(oor), 0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    phase_offset = 32'd300;
    short_preamble_detected = 1'b1;
    sample_in_strobe = 1'b1;
    tick();
    short_preamble_detected = 1'b0;
    chk("same_det_phase", rot_phase, 0);
    chk("same_det_locked", 32'(locked), 1);
    send(32'd1);
    chk("same_det_first", rot_phase, 0);
    send(32'd2);
    chk("same_det_second", rot_phase, 300);
    idle_in();

    clear = 1'b1;
    short_preamble_detected = 1'b1;
    phase_offset = 32'd700;
    tick();
    idle_in();
    chk("clr_det_locked", 32'(locked), 0);
    send(32'd3);
    chk("clr_det_ph0", rot_phase, 0);
    send(32'd4);
    chk("clr_det_ph1", rot_phase, 0);
    idle_in();
    phase_offset = 32'd50;
    short_preamble_detected = 1'b1;
    tick();
    short_preamble_detected = 1'b0;
    chk("relock", 32'(locked), 1);
    send(32'd5);
    chk("relock_ph0", rot_phase, 0);
    send(32'd6);
    chk("relock_ph1", rot_phase, 50);
    idle_in();
    repeat (6) tick();

    enable = 1'b0;
    sample_in_strobe = 1'b1;
    tick();
    chk("dis_rot_in_stb", 32'(rot_in_stb), 0);
    chk("dis_hold_phase", rot_phase, 50);
    enable = 1'b1;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_sample_phase", rot_phase, 100);
    send(32'd7);
    chk("after_clr_phase", rot_phase, 0);
    chk("after_clr_locked", 32'(locked), 0);
    idle_in();
    repeat (6) tick();
    chk("no_ovf_yet", 32'(overflow), 0);

    model_en = 1'b0;
    for (int k = 0; k < 15; k++) send(32'(k));
    idle_in();
    tick();
    chk("ovf_15", 32'(overflow), 0);
    send(32'd15);
    idle_in();
    tick();
    tick();
    chk("ovf_16", 32'(overflow), 1);
    spur = 1'b1;
    repeat (16) tick();
    spur = 1'b0;
    tick();
    chk("ovf_sticky", 32'(overflow), 1);

    do_reset();
    chk("ovf_reset", 32'(overflow), 0);
    spur = 1'b1;
    spur_data = 32'h1234_5678;
    tick();
    spur = 1'b0;
    chk("spur_stb", 32'(sample_out_strobe), 1);
    chk("spur_data", sample_out, 32'h1234_5678);
    chk("spur_ovf", 32'(overflow), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
